cmd_arbiter: RTL and testbench

Two-requester arbiter that shares the single life-engine command port (`cmd`/`cmd_arg0`/`cmd_valid`/`cmd_ready`/`cmd_res` of `top`) between a host bridge (requester 0) and an on-chip client such as an auto-advance timer or cell scanner (requester 1). It grants fairly with round-robin, issues one command at a time, waits for engine completion, and routes the 32-bit result back to the originator. An optional watchdog aborts a hung command with an error result.

---
 rtl/cmd_arbiter_if.sv | 38 +++
 rtl/cmd_arbiter.sv | 155 +++++++++++++++
 tb/tb_cmd_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_arbiter_if.sv
// Requester and engine command/result signals between the arbiter and its
// neighbours. The slave view is the arbiter itself; the master view is the
// surrounding logic (requesters plus the life engine).
interface cmd_arbiter_if;
    logic [2:0]  rq0_cmd;
    logic [2:0]  rq1_cmd;
    logic [31:0] rq0_arg0;
    logic [31:0] rq1_arg0;
    logic        rq0_valid;
    logic        rq1_valid;
    logic        rq0_ready;
    logic        rq1_ready;
    logic        rq0_res_valid;
    logic        rq1_res_valid;
    logic [31:0] rq_res;
    logic        rq_err;
    logic [2:0]  eng_cmd;
    logic [31:0] eng_arg0;
    logic        eng_cmd_valid;
    logic        eng_cmd_ready;
    logic [31:0] eng_cmd_res;
    logic        grant;
    logic        busy;

    modport slave (
        input  rq0_cmd, rq1_cmd, rq0_arg0, rq1_arg0, rq0_valid, rq1_valid,
        input  eng_cmd_ready, eng_cmd_res,
        output rq0_ready, rq1_ready, rq0_res_valid, rq1_res_valid,
        output rq_res, rq_err, eng_cmd, eng_arg0, eng_cmd_valid, grant, busy
    );

    modport master (
        output rq0_cmd, rq1_cmd, rq0_arg0, rq1_arg0, rq0_valid, rq1_valid,
        output eng_cmd_ready, eng_cmd_res,
        input  rq0_ready, rq1_ready, rq0_res_valid, rq1_res_valid,
        input  rq_res, rq_err, eng_cmd, eng_arg0, eng_cmd_valid, grant, busy
    );
endinterface

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter sharing the single life-engine command port between a
// host bridge (requester 0) and an on-chip client (requester 1). One command
// is in flight at a time; the result is routed back to its originator, and an
// optional watchdog replaces a hung command's result with an error marker.
module cmd_arbiter #(
    parameter int unsigned TIMEOUT = 32'd0
) (
    input  logic         clk,
    input  logic         reset,
    cmd_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [31:0] TO_LIMIT  = TIMEOUT;
    localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

    state_t      state_r;
    logic        last_r;
    logic [31:0] wdog_r;
    logic        grant_r;
    logic        busy_r;
    logic        eng_cmd_valid_r;
    logic [2:0]  eng_cmd_r;
    logic [31:0] eng_arg0_r;
    logic        rq0_ready_r;
    logic        rq1_ready_r;
    logic        rq0_res_valid_r;
    logic        rq1_res_valid_r;
    logic [31:0] rq_res_r;
    logic        rq_err_r;

    logic        any_req_s;
    logic        win_s;
    logic [31:0] wdog_nxt_s;
    logic        wd_hit_s;

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        any_req_s = bus.rq0_valid | bus.rq1_valid;
        if (bus.rq0_valid && bus.rq1_valid) begin
            win_s = ~last_r;
        end else if (bus.rq1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Watchdog compare: fires on the WAIT cycle that brings the count to TIMEOUT.
    always_comb begin
        wdog_nxt_s = wdog_r + 32'd1;
        if (TO_LIMIT != 32'd0) begin
            wd_hit_s = (wdog_nxt_s == TO_LIMIT);
        end else begin
            wd_hit_s = 1'b0;
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            last_r          <= 1'b1;
            wdog_r          <= 32'd0;
            grant_r         <= 1'b0;
            busy_r          <= 1'b0;
            eng_cmd_valid_r <= 1'b0;
            eng_cmd_r       <= 3'd0;
            eng_arg0_r      <= 32'd0;
            rq0_ready_r     <= 1'b0;
            rq1_ready_r     <= 1'b0;
            rq0_res_valid_r <= 1'b0;
            rq1_res_valid_r <= 1'b0;
            rq_res_r        <= 32'd0;
            rq_err_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // An engine still finishing an aborted command blocks new grants.
                    if (bus.eng_cmd_ready && any_req_s) begin
                        grant_r         <= win_s;
                        busy_r          <= 1'b1;
                        eng_cmd_valid_r <= 1'b1;
                        rq0_ready_r     <= ~win_s;
                        rq1_ready_r     <= win_s;
                        eng_cmd_r       <= win_s ? bus.rq1_cmd : bus.rq0_cmd;
                        eng_arg0_r      <= win_s ? bus.rq1_arg0 : bus.rq0_arg0;
                        state_r         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    eng_cmd_valid_r <= 1'b0;
                    rq0_ready_r     <= 1'b0;
                    rq1_ready_r     <= 1'b0;
                    wdog_r          <= 32'd0;
                    state_r         <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over a simultaneous watchdog expiry.
                    if (bus.eng_cmd_ready) begin
                        rq_res_r        <= bus.eng_cmd_res;
                        rq_err_r        <= 1'b0;
                        rq0_res_valid_r <= ~grant_r;
                        rq1_res_valid_r <= grant_r;
                        state_r         <= ST_RESP;
                    end else begin
                        wdog_r <= wdog_nxt_s;
                        if (wd_hit_s) begin
                            rq_res_r        <= ERR_RESULT;
                            rq_err_r        <= 1'b1;
                            rq0_res_valid_r <= ~grant_r;
                            rq1_res_valid_r <= grant_r;
                            state_r         <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    rq0_res_valid_r <= 1'b0;
                    rq1_res_valid_r <= 1'b0;
                    busy_r          <= 1'b0;
                    last_r          <= grant_r;
                    state_r         <= ST_IDLE;
                end
                default: begin
                    eng_cmd_valid_r <= 1'b0;
                    rq0_ready_r     <= 1'b0;
                    rq1_ready_r     <= 1'b0;
                    rq0_res_valid_r <= 1'b0;
                    rq1_res_valid_r <= 1'b0;
                    busy_r          <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant         = grant_r;
    assign bus.busy          = busy_r;
    assign bus.eng_cmd_valid = eng_cmd_valid_r;
    assign bus.eng_cmd       = eng_cmd_r;
    assign bus.eng_arg0      = eng_arg0_r;
    assign bus.rq0_ready     = rq0_ready_r;
    assign bus.rq1_ready     = rq1_ready_r;
    assign bus.rq0_res_valid = rq0_res_valid_r;
    assign bus.rq1_res_valid = rq1_res_valid_r;
    assign bus.rq_res        = rq_res_r;
    assign bus.rq_err        = rq_err_r;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Randomized bench for cmd_arbiter: two requester models and an engine model
// drive the DUT; a cycle-schedule reference model predicts every output.
module tb_cmd_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cmd_arbiter_if bus();
    cmd_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_total = 0;
    int n_bad   = 0;

    // requester models
    logic        v[2];
    logic [2:0]  rc[2];
    logic [31:0] ra[2];
    int          prob[2];
    logic        dq[2];
    logic [2:0]  dqc[2];
    logic [31:0] dqa[2];

    // engine model
    int          e_cnt;
    logic        e_inflight;
    logic        e_ready;
    logic [31:0] e_res;
    logic [31:0] e_pend_res;
    int          dmin, dmax;
    logic        force_res_en;
    logic [31:0] force_res;

    // reference model: schedule of the command in flight plus held outputs
    int          m_owner, m_issue_at, m_resp_at;
    logic        m_last, m_grant, m_err;
    logic [2:0]  m_cmd;
    logic [31:0] m_arg, m_res;

    logic rst_req, checks_on, track_starve, found;
    int   cyc, n_rv0, n_to, w0;
    logic gq[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic rdy[2];
        int w;
        @(negedge clk);
        cyc++;
        if (checks_on) begin
            check_val("busy",     32'(bus.busy),          32'(m_owner >= 0));
            check_val("grant",    32'(bus.grant),         32'(m_grant));
            check_val("cmd_vld",  32'(bus.eng_cmd_valid), 32'(cyc == m_issue_at));
            check_val("rq0_rdy",  32'(bus.rq0_ready),     32'(cyc == m_issue_at && m_owner == 0));
            check_val("rq1_rdy",  32'(bus.rq1_ready),     32'(cyc == m_issue_at && m_owner == 1));
            check_val("rq0_rv",   32'(bus.rq0_res_valid), 32'(cyc == m_resp_at && m_owner == 0));
            check_val("rq1_rv",   32'(bus.rq1_res_valid), 32'(cyc == m_resp_at && m_owner == 1));
            check_val("eng_cmd",  32'(bus.eng_cmd),       32'(m_cmd));
            check_val("eng_arg",  bus.eng_arg0,           m_arg);
            check_val("rq_res",   bus.rq_res,             m_res);
            check_val("rq_err",   32'(bus.rq_err),        32'(m_err));
        end
        if (bus.rq0_res_valid) n_rv0++;
        if ((bus.rq0_res_valid || bus.rq1_res_valid) && bus.rq_err) n_to++;
        if (bus.rq0_ready || bus.rq1_ready) gq.push_back(bus.rq1_ready);
        if (track_starve) begin
            if (bus.rq1_ready && v[0]) w0++;
            if (bus.rq0_ready) check_val("rq0_starve", 32'(w0 > 1), 32'd0);
        end

        // requesters: drop on accept, then maybe raise a new request
        rdy[0] = bus.rq0_ready;
        rdy[1] = bus.rq1_ready;
        for (int n = 0; n < 2; n++) begin
            if (rdy[n]) v[n] = 1'b0;
            if (!v[n]) begin
                if (dq[n]) begin
                    v[n] = 1'b1; rc[n] = dqc[n]; ra[n] = dqa[n]; dq[n] = 1'b0;
                    if (n == 0) w0 = 0;
                end else if (int'($urandom_range(99)) < prob[n]) begin
                    v[n] = 1'b1; rc[n] = 3'($urandom_range(7)); ra[n] = $urandom;
                    if (n == 0) w0 = 0;
                end
            end
        end

        // engine: busy countdown, completion cycle carries the result
        if (e_cnt > 0) begin
            e_ready = 1'b0; e_cnt--; e_res = $urandom;
        end else begin
            e_ready = 1'b1;
            e_res = e_inflight ? e_pend_res : $urandom;
            e_inflight = 1'b0;
        end
        if (rst_req) begin
            e_cnt = 0; e_inflight = 1'b0;
        end else if (bus.eng_cmd_valid && e_ready) begin
            e_cnt = $urandom_range(dmax, dmin);
            e_inflight = 1'b1;
            e_pend_res = force_res_en ? force_res : $urandom;
        end

        reset             = ~rst_req;
        bus.rq0_valid     = v[0];  bus.rq1_valid = v[1];
        bus.rq0_cmd       = rc[0]; bus.rq1_cmd   = rc[1];
        bus.rq0_arg0      = ra[0]; bus.rq1_arg0  = ra[1];
        bus.eng_cmd_ready = e_ready;
        bus.eng_cmd_res   = e_res;

        // reference model: consume this cycle's inputs, schedule next outputs
        if (rst_req) begin
            m_owner = -1; m_issue_at = -1; m_resp_at = -1; m_last = 1'b1;
            m_grant = 1'b0; m_cmd = 3'd0; m_arg = 32'd0; m_res = 32'd0; m_err = 1'b0;
        end else if (m_owner >= 0) begin
            if (cyc == m_resp_at) begin
                m_last = (m_owner == 1); m_owner = -1;
            end else if (m_resp_at < 0 && cyc > m_issue_at) begin
                if (e_ready) begin
                    m_resp_at = cyc + 1; m_res = e_res; m_err = 1'b0;
                end else if (cyc == m_issue_at + TO) begin
                    m_resp_at = cyc + 1; m_res = 32'hFFFF_FFFF; m_err = 1'b1;
                end
            end
        end else if (e_ready && (v[0] || v[1])) begin
            w = (v[0] && v[1]) ? int'(!m_last) : (v[1] ? 1 : 0);
            m_owner = w; m_issue_at = cyc + 1; m_resp_at = -1;
            m_grant = (w == 1); m_cmd = rc[w]; m_arg = ra[w];
        end
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b0; rc[n] = 3'd0; ra[n] = 32'd0; prob[n] = 0; dq[n] = 1'b0;
            dqc[n] = 3'd0; dqa[n] = 32'd0;
        end
        e_cnt = 0; e_inflight = 1'b0; e_ready = 1'b1; e_res = 32'd0; e_pend_res = 32'd0;
        dmin = 1; dmax = 1; force_res_en = 1'b0; force_res = 32'd0;
        cyc = 0; n_rv0 = 0; n_to = 0; w0 = 0; track_starve = 1'b0; found = 1'b0;
        m_owner = -1; m_issue_at = -1; m_resp_at = -1; m_last = 1'b1;
        m_grant = 1'b0; m_cmd = 3'd0; m_arg = 32'd0; m_res = 32'd0; m_err = 1'b0;
        reset = 1'b0;
        bus.rq0_valid = 1'b0; bus.rq1_valid = 1'b0; bus.rq0_cmd = 3'd0; bus.rq1_cmd = 3'd0;
        bus.rq0_arg0 = 32'd0; bus.rq1_arg0 = 32'd0; bus.eng_cmd_ready = 1'b1; bus.eng_cmd_res = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy",  32'(bus.busy),          32'd0);
        check_val("rst_grant", 32'(bus.grant),         32'd0);
        check_val("rst_cvld",  32'(bus.eng_cmd_valid), 32'd0);
        check_val("rst_rdy",   32'({bus.rq0_ready, bus.rq1_ready}), 32'd0);
        check_val("rst_rv",    32'({bus.rq0_res_valid, bus.rq1_res_valid}), 32'd0);
        check_val("rst_res",   bus.rq_res,             32'd0);
        check_val("rst_err",   32'(bus.rq_err),        32'd0);
        check_val("rst_arg",   bus.eng_arg0,           32'd0);
        rst_req = 1'b1; checks_on = 1'b0;
        step();
        rst_req = 1'b0; checks_on = 1'b1;

        // single SEED from rq0, engine completes 5 cycles after accept
        dmin = 4; dmax = 4; force_res_en = 1'b1; force_res = 32'h5EED_0042;
        dq[0] = 1'b1; dqc[0] = 3'd1; dqa[0] = 32'hCAFE_BABE; n_rv0 = 0;
        repeat (14) step();
        check_val("seed_pulses", 32'(n_rv0), 32'd1);
        check_val("seed_res",    bus.rq_res, 32'h5EED_0042);
        check_val("seed_arg",    bus.eng_arg0, 32'hCAFE_BABE);

        // READ_CELL returning 1, then a command returning 0
        force_res = 32'd1; dq[0] = 1'b1; dqc[0] = 3'd2; dqa[0] = $urandom;
        repeat (12) step();
        check_val("rc_res1", bus.rq_res, 32'd1);
        check_val("rc_err1", 32'(bus.rq_err), 32'd0);
        force_res = 32'd0; dq[1] = 1'b1; dqc[1] = 3'd2; dqa[1] = $urandom;
        repeat (12) step();
        check_val("rc_res0", bus.rq_res, 32'd0);

        // hung engine: watchdog fires, no issue until the engine recovers
        force_res_en = 1'b0; dmin = 30; dmax = 30; n_to = 0;
        dq[0] = 1'b1; dqc[0] = 3'd3; dqa[0] = $urandom;
        repeat (14) step();
        check_val("to_count", 32'(n_to), 32'd1);
        check_val("to_res",   bus.rq_res, 32'hFFFF_FFFF);
        check_val("to_err",   32'(bus.rq_err), 32'd1);
        dmin = 2; dmax = 2; dq[1] = 1'b1; dqc[1] = 3'd4; dqa[1] = $urandom;
        repeat (30) step();
        check_val("to_recover_cnt", 32'(n_to), 32'd1);
        check_val("to_recover_err", 32'(bus.rq_err), 32'd0);

        // random traffic: sporadic rq0 against continuous rq1, then mixed
        dmin = 1; dmax = 10; prob[0] = 15; prob[1] = 100; track_starve = 1'b1;
        repeat (600) step();
        track_starve = 1'b0; prob[0] = 40; prob[1] = 40;
        repeat (600) step();

        // reset while waiting on the engine
        prob[0] = 0; prob[1] = 0;
        repeat (40) step();
        dmin = 6; dmax = 6; dq[1] = 1'b1; dqc[1] = 3'd5; dqa[1] = $urandom;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (m_owner >= 0 && m_resp_at < 0 && cyc > m_issue_at) found = 1'b1;
        end
        check_val("reach_wait", 32'(found), 32'd1);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0; n_rv0 = 0; gq.delete();
        dmin = 2; dmax = 2; prob[0] = 100; prob[1] = 100;
        step();
        check_val("rw_busy", 32'(bus.busy), 32'd0);
        check_val("rw_res",  bus.rq_res, 32'd0);
        check_val("rw_arg",  bus.eng_arg0, 32'd0);
        check_val("rw_rv",   32'({bus.rq0_res_valid, bus.rq1_res_valid}), 32'd0);
        repeat (40) step();
        check_val("alt_count", 32'(gq.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check_val($sformatf("alt%0d", i), 32'(gq[i]), 32'(i % 2));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
